aemb2_xslq: RTL and testbench

AEMB2_XSLQ -- requirements
Module: aemb2_xslq

---
 rtl/aemb2_xslq.sv | 131 +++++++++++++
 tb/tb_aemb2_xslq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb2_xslq.sv
// XSEL channel bus master: turns PUT/GET pipeline ops into single strobe
// transfers, with blocking, non-blocking and optional timeout handling.
module aemb2_xslq #(
  parameter int XWB  = 3,
  parameter int TOUT = 0
) (
  input  logic           gclk,
  input  logic           grst,
  input  logic           dena,
  input  logic [15:0]    imm_of,
  input  logic [5:0]     opc_of,
  input  logic [31:0]    opa_of,
  output logic [XWB-1:0] xwb_adr_o,
  output logic [31:0]    xwb_dat_o,
  output logic [3:0]     xwb_sel_o,
  output logic           xwb_tag_o,
  output logic           xwb_wre_o,
  output logic           xwb_stb_o,
  output logic           xwb_cyc_o,
  input  logic [31:0]    xwb_dat_i,
  input  logic           xwb_tag_i,
  input  logic           xwb_ack_i,
  output logic           xwb_fb,
  output logic [31:0]    xwb_mx,
  output logic           xwb_err,
  output logic           xwb_inv
);

  localparam int CW = ($clog2(TOUT + 1) > 5) ? $clog2(TOUT + 1) : 5;
  localparam logic [CW-1:0] TLIM = CW'((TOUT > 0) ? TOUT - 1 : 0);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [XWB-1:0] r_adr;
  logic [31:0]   r_dat;
  logic          r_tag;
  logic          r_wre;
  logic          r_nblk;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mx;
  logic          r_err;
  logic          r_inv;

  logic w_xsel;
  logic w_tout;
  logic w_done;
  logic w_abort;
  logic w_fb;
  logic w_accept;
  logic w_unused;

  assign w_xsel   = (opc_of[5:3] == 3'b011);
  assign w_unused = ^{imm_of[12:XWB], opc_of[2:0]};

  always_ff @(posedge gclk) begin
    if (grst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // r_cnt holds the number of REQ cycles already spent, so the TOUT-th cycle sees TOUT-1
  always_comb begin
    w_nextState = r_state;
    w_tout      = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_fb        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: w_fb = 1'b1;
      REQ: begin
        w_tout  = (TOUT > 0) && !r_nblk && (r_cnt == TLIM);
        w_done  = xwb_ack_i;
        w_abort = !xwb_ack_i && (r_nblk || w_tout);
        w_fb    = xwb_ack_i || w_abort;
      end
      default: w_fb = 1'b1;
    endcase
    w_accept = dena && w_xsel && w_fb;
    if (w_accept)               w_nextState = REQ;
    else if (w_done || w_abort) w_nextState = IDLE;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_adr  <= '0;
      r_dat  <= '0;
      r_tag  <= 1'b0;
      r_wre  <= 1'b0;
      r_nblk <= 1'b0;
      r_cnt  <= '0;
      r_mx   <= '0;
      r_err  <= 1'b0;
      r_inv  <= 1'b0;
    end else begin
      if (w_done) begin
        if (!r_wre) r_mx <= xwb_dat_i;
        r_err <= 1'b0;
        r_inv <= !r_wre && (xwb_tag_i != r_tag);
      end else if (w_abort) begin
        r_err <= 1'b1;
        r_inv <= 1'b0;
      end
      // A new accept may overlap the completion of the previous transfer
      if (w_accept) begin
        r_adr  <= imm_of[XWB-1:0];
        r_wre  <= imm_of[15];
        r_nblk <= imm_of[14];
        r_tag  <= imm_of[13];
        r_dat  <= imm_of[15] ? opa_of : 32'h0;
        r_cnt  <= '0;
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign xwb_adr_o = r_adr;
  assign xwb_dat_o = r_dat;
  assign xwb_sel_o = 4'hF;
  assign xwb_tag_o = r_tag;
  assign xwb_wre_o = r_wre;
  assign xwb_stb_o = (r_state == REQ);
  assign xwb_cyc_o = (r_state == REQ);
  assign xwb_fb    = w_fb;
  assign xwb_mx    = r_mx;
  assign xwb_err   = r_err;
  assign xwb_inv   = r_inv;

endmodule

// File: tb/tb_aemb2_xslq.sv
// Self-checking bench for aemb2_xslq: directed scenarios plus random transfers
// scored against a transaction-level model of strobe length and status.
module tb_aemb2_xslq;

  logic        gclk = 1'b0;
  logic        grst;
  logic        dena;
  logic [15:0] imm_of;
  logic [5:0]  opc_of;
  logic [31:0] opa_of;
  logic [31:0] xwb_dat_i;
  logic        xwb_tag_i;
  logic        xwb_ack_i;

  logic [2:0]  adr;
  logic [31:0] datO;
  logic [3:0]  sel;
  logic        tagO, wre, stb, cyc, fb, err, inv;
  logic [31:0] mx;

  logic [2:0]  adr0;
  logic [31:0] datO0;
  logic [3:0]  sel0;
  logic        tagO0, wre0, stb0, cyc0, fb0, err0, inv0;
  logic [31:0] mx0;

  int total = 0;
  int bad   = 0;

  logic [31:0] expMx;
  logic        expErr;
  logic        expInv;

  aemb2_xslq #(.XWB(3), .TOUT(4)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .imm_of(imm_of), .opc_of(opc_of),
    .opa_of(opa_of), .xwb_adr_o(adr), .xwb_dat_o(datO), .xwb_sel_o(sel),
    .xwb_tag_o(tagO), .xwb_wre_o(wre), .xwb_stb_o(stb), .xwb_cyc_o(cyc),
    .xwb_dat_i(xwb_dat_i), .xwb_tag_i(xwb_tag_i), .xwb_ack_i(xwb_ack_i),
    .xwb_fb(fb), .xwb_mx(mx), .xwb_err(err), .xwb_inv(inv)
  );

  aemb2_xslq #(.XWB(3), .TOUT(0)) dut0 (
    .gclk(gclk), .grst(grst), .dena(dena), .imm_of(imm_of), .opc_of(opc_of),
    .opa_of(opa_of), .xwb_adr_o(adr0), .xwb_dat_o(datO0), .xwb_sel_o(sel0),
    .xwb_tag_o(tagO0), .xwb_wre_o(wre0), .xwb_stb_o(stb0), .xwb_cyc_o(cyc0),
    .xwb_dat_i(xwb_dat_i), .xwb_tag_i(xwb_tag_i), .xwb_ack_i(xwb_ack_i),
    .xwb_fb(fb0), .xwb_mx(mx0), .xwb_err(err0), .xwb_inv(inv0)
  );

  always #5 gclk = ~gclk;

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit put, input bit nb, input bit ctl,
                               input logic [2:0] ch, input logic [31:0] opa);
    logic [15:0] imm;
    imm       = 16'($urandom);
    imm[15]   = put;
    imm[14]   = nb;
    imm[13]   = ctl;
    imm[2:0]  = ch;
    dena      = en;
    imm_of    = imm;
    opc_of    = {3'b011, 3'($urandom)};
    opa_of    = opa;
  endtask

  task automatic checkReset;
    checkOutput("rstStb", {31'b0, stb}, 32'd0);
    checkOutput("rstCyc", {31'b0, cyc}, 32'd0);
    checkOutput("rstFb", {31'b0, fb}, 32'd1);
    checkOutput("rstSel", {28'b0, sel}, 32'hF);
    checkOutput("rstAdr", {29'b0, adr}, 32'd0);
    checkOutput("rstDat", datO, 32'd0);
    checkOutput("rstTag", {31'b0, tagO}, 32'd0);
    checkOutput("rstWre", {31'b0, wre}, 32'd0);
    checkOutput("rstMx", mx, 32'd0);
    checkOutput("rstErr", {31'b0, err}, 32'd0);
    checkOutput("rstInv", {31'b0, inv}, 32'd0);
  endtask

  // One transfer: the model decides how long stb lasts and what status results
  task automatic runTxn(input bit put, input bit nb, input bit ctl, input logic [2:0] ch,
                        input logic [31:0] opa, input int ackAt,
                        input logic [31:0] datI, input bit tagI);
    int  lim;
    int  last;
    bit  acked;
    lim   = nb ? 1 : 4;
    acked = (ackAt >= 1) && (ackAt <= lim);
    last  = acked ? ackAt : lim;
    applyStimulus(1'b1, put, nb, ctl, ch, opa);
    xwb_ack_i = 1'b0;
    #1;
    checkOutput("acceptFb", {31'b0, fb}, 32'd1);
    checkOutput("acceptStb", {31'b0, stb}, 32'd0);
    for (int c = 1; c <= last; c++) begin
      tick;
      if (c < last) applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom);
      else          dena = 1'b0;
      xwb_ack_i = (c == ackAt);
      xwb_dat_i = (c == ackAt) ? datI : $urandom;
      xwb_tag_i = (c == ackAt) ? tagI : 1'($urandom);
      #1;
      checkOutput("reqStb", {31'b0, stb}, 32'd1);
      checkOutput("reqCyc", {31'b0, cyc}, 32'd1);
      checkOutput("reqAdr", {29'b0, adr}, {29'b0, ch});
      checkOutput("reqWre", {31'b0, wre}, {31'b0, put});
      checkOutput("reqDat", datO, put ? opa : 32'h0);
      checkOutput("reqTag", {31'b0, tagO}, {31'b0, ctl});
      checkOutput("reqSel", {28'b0, sel}, 32'hF);
      checkOutput("reqFb", {31'b0, fb}, (c == last) ? 32'd1 : 32'd0);
    end
    tick;
    dena      = 1'b0;
    xwb_ack_i = 1'b0;
    #1;
    if (acked) begin
      if (!put) expMx = datI;
      expErr = 1'b0;
      expInv = !put && (tagI != ctl);
    end else begin
      expErr = 1'b1;
      expInv = 1'b0;
    end
    checkOutput("endStb", {31'b0, stb}, 32'd0);
    checkOutput("endMx", mx, expMx);
    checkOutput("endErr", {31'b0, err}, {31'b0, expErr});
    checkOutput("endInv", {31'b0, inv}, {31'b0, expInv});
    xwb_ack_i = 1'b1;
    xwb_dat_i = $urandom;
    xwb_tag_i = 1'($urandom);
    tick;
    xwb_ack_i = 1'b0;
    #1;
    checkOutput("idleAckMx", mx, expMx);
    checkOutput("idleAckErr", {31'b0, err}, {31'b0, expErr});
    checkOutput("idleAckStb", {31'b0, stb}, 32'd0);
  endtask

  initial begin
    grst = 1'b1; dena = 1'b0; imm_of = '0; opc_of = '0; opa_of = '0;
    xwb_dat_i = '0; xwb_tag_i = 1'b0; xwb_ack_i = 1'b0;
    expMx = '0; expErr = 1'b0; expInv = 1'b0;
    tick;
    tick;
    grst = 1'b0;
    #1;
    checkReset();

    // Untimed instance waits past the point where the TOUT=4 instance gives up
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h0);
    #1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      dena = 1'b0;
      #1;
    end
    checkOutput("noToutStb", {31'b0, stb0}, 32'd1);
    checkOutput("noToutFb", {31'b0, fb0}, 32'd0);
    checkOutput("toutStbGone", {31'b0, stb}, 32'd0);
    tick;
    xwb_ack_i = 1'b1; xwb_dat_i = 32'hCAFEF00D; xwb_tag_i = 1'b0;
    #1;
    checkOutput("noToutAckFb", {31'b0, fb0}, 32'd1);
    tick;
    xwb_ack_i = 1'b0;
    #1;
    checkOutput("noToutEndStb", {31'b0, stb0}, 32'd0);
    checkOutput("noToutMx", mx0, 32'hCAFEF00D);
    checkOutput("noToutErr", {31'b0, err0}, 32'd0);
    checkOutput("toutErr", {31'b0, err}, 32'd1);
    checkOutput("toutMx", mx, 32'd0);
    grst = 1'b1;
    tick;
    grst = 1'b0;
    expMx = '0; expErr = 1'b0; expInv = 1'b0;

    runTxn(1'b0, 1'b0, 1'b0, 3'd5, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    runTxn(1'b1, 1'b1, 1'b0, 3'd1, 32'h00001234, 0, 32'h0, 1'b0);
    runTxn(1'b0, 1'b0, 1'b0, 3'd4, 32'h0, 0, 32'h0, 1'b0);
    runTxn(1'b0, 1'b0, 1'b0, 3'd6, 32'h0, 4, 32'hA5A5C3C3, 1'b0);
    runTxn(1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 1, 32'h0BADF00D, 1'b1);
    runTxn(1'b0, 1'b0, 1'b1, 3'd7, 32'h0, 1, 32'h11112222, 1'b0);
    runTxn(1'b0, 1'b0, 1'b0, 3'd7, 32'h0, 2, 32'h33334444, 1'b0);

    // Back-to-back PUTs with no idle gap
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000AAAA);
    xwb_ack_i = 1'b0;
    tick;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 32'h0000BBBB);
    xwb_ack_i = 1'b1;
    #1;
    checkOutput("b2bStb1", {31'b0, stb}, 32'd1);
    checkOutput("b2bAdr1", {29'b0, adr}, 32'd1);
    checkOutput("b2bDat1", datO, 32'h0000AAAA);
    checkOutput("b2bFb1", {31'b0, fb}, 32'd1);
    tick;
    dena = 1'b0;
    #1;
    checkOutput("b2bStb2", {31'b0, stb}, 32'd1);
    checkOutput("b2bAdr2", {29'b0, adr}, 32'd2);
    checkOutput("b2bDat2", datO, 32'h0000BBBB);
    tick;
    xwb_ack_i = 1'b0;
    #1;
    expErr = 1'b0; expInv = 1'b0;
    checkOutput("b2bEndStb", {31'b0, stb}, 32'd0);
    checkOutput("b2bErr", {31'b0, err}, 32'd0);
    checkOutput("b2bMx", mx, expMx);

    // Non-XSEL opcodes are not accepted
    dena = 1'b1; opc_of = 6'b101010; imm_of = 16'h8005;
    tick;
    dena = 1'b0;
    #1;
    checkOutput("nonXselStb", {31'b0, stb}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      runTxn(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom,
             int'($urandom_range(0, 5)), $urandom, 1'($urandom));
    end

    // Reset during the 2nd strobe cycle of a blocking GET
    runTxn(1'b0, 1'b0, 1'b0, 3'd3, 32'h0, 1, 32'h5A5A0001, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 32'h0);
    xwb_ack_i = 1'b0;
    tick;
    dena = 1'b0;
    tick;
    grst = 1'b1; xwb_ack_i = 1'b1; xwb_dat_i = 32'hFFFF0000; xwb_tag_i = 1'b1;
    #1;
    checkOutput("midRstStb", {31'b0, stb}, 32'd1);
    tick;
    grst = 1'b0;
    #1;
    checkReset();
    tick;
    xwb_ack_i = 1'b0;
    #1;
    checkOutput("lateAckMx", mx, 32'd0);
    checkOutput("lateAckErr", {31'b0, err}, 32'd0);
    checkOutput("lateAckStb", {31'b0, stb}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
